// File: rtl/hwpe_stream_traffic_source.sv
// hwpe_stream_traffic_source: burst stream source with reproducible LFSR-driven valid stalls
module hwpe_stream_traffic_source #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic [7:0]  STALL_THRESH = 8'd0,
  parameter logic [15:0] STALL_SEED   = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [15:0]             num_beats_i,
  input  logic                    pattern_i,
  output logic                    data_valid_o,
  output logic [DATA_WIDTH-1:0]   data_data_o,
  output logic [DATA_WIDTH/8-1:0] data_strb_o,
  input  logic                    data_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [15:0]             beat_cnt_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [15:0] count;
  logic pattern;
  logic [15:0] stall_lfsr;
  logic [31:0] data_lfsr;
  logic hs, last, offer, stall_fb;
  logic [15:0] nxt_idx;
  logic [31:0] data_lfsr_nxt, lfsr_word;
  logic [DATA_WIDTH-1:0] gen;
  // handshake bookkeeping and the value of the next beat to offer
  always_comb begin
    hs            = data_valid_o & data_ready_i;
    last          = hs && (beat_cnt_o == count - 16'd1);
    nxt_idx       = beat_cnt_o + {15'd0, hs};
    data_lfsr_nxt = {1'b0, data_lfsr[31:1]} ^ (data_lfsr[0] ? 32'h8020_0003 : 32'h0);
    lfsr_word     = hs ? data_lfsr_nxt : data_lfsr;
    gen           = pattern ? {(DATA_WIDTH/32){lfsr_word}} : {{(DATA_WIDTH-16){1'b0}}, nxt_idx};
    offer         = stall_lfsr[7:0] >= STALL_THRESH;
    stall_fb      = stall_lfsr[0] ^ stall_lfsr[2] ^ stall_lfsr[3] ^ stall_lfsr[5];
  end
  // burst FSM; every output is a register so ready never reaches an output combinationally
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state        <= IDLE;
      count        <= '0;
      pattern      <= 1'b0;
      stall_lfsr   <= STALL_SEED;
      data_lfsr    <= 32'hFFFF_FFFF;
      data_valid_o <= 1'b0;
      data_data_o  <= '0;
      data_strb_o  <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      beat_cnt_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            beat_cnt_o <= '0;
            data_lfsr  <= 32'hFFFF_FFFF;
            count      <= num_beats_i;
            pattern    <= pattern_i;
            state      <= (num_beats_i != 16'd0) ? RUN : DONE;
            busy_o     <= num_beats_i != 16'd0;
            done_o     <= num_beats_i == 16'd0;
          end
        end
        RUN: begin
          stall_lfsr <= {stall_fb, stall_lfsr[15:1]};
          if (hs) begin
            beat_cnt_o <= beat_cnt_o + 16'd1;
            data_lfsr  <= data_lfsr_nxt;
          end
          if (last) begin
            data_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b1;
            state        <= DONE;
          end else if (!data_valid_o || hs) begin
            data_valid_o <= offer;
            data_data_o  <= gen;
            data_strb_o  <= '1;
          end
        end
        default: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hwpe_stream_traffic_source.sv
// tb_hwpe_stream_traffic_source: directed checks plus a randomized-ready burst
module tb_hwpe_stream_traffic_source;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, clear, start, pattern, ready;
  logic [15:0] num;
  logic valid, busy, done;
  logic [63:0] data;
  logic [7:0] strb;
  logic [15:0] cnt;
  logic r_clear, r_start, r_ready;
  logic [15:0] r_num;
  logic r_valid, r_busy, r_done;
  logic [31:0] r_data;
  logic [3:0] r_strb;
  logic [15:0] r_cnt;
  int total = 0;
  int bad = 0;
  hwpe_stream_traffic_source #(.DATA_WIDTH(64), .STALL_THRESH(8'd0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start), .num_beats_i(num),
    .pattern_i(pattern), .data_valid_o(valid), .data_data_o(data), .data_strb_o(strb),
    .data_ready_i(ready), .busy_o(busy), .done_o(done), .beat_cnt_o(cnt));
  hwpe_stream_traffic_source #(.DATA_WIDTH(32), .STALL_THRESH(8'd128)) u_rnd (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(r_clear), .start_i(r_start), .num_beats_i(r_num),
    .pattern_i(1'b0), .data_valid_o(r_valid), .data_data_o(r_data), .data_strb_o(r_strb),
    .data_ready_i(r_ready), .busy_o(r_busy), .done_o(r_done), .beat_cnt_o(r_cnt));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [15:0] n, input logic p);
    num = n; pattern = p; start = 1'b1;
    step();
    start = 1'b0;
  endtask
  int expd, drops, dones, bad_data, tail;
  logic prev_v, prev_hs, h;
  initial begin
    rst_n = 0; clear = 0; start = 0; pattern = 0; ready = 1; num = 0;
    r_clear = 0; r_start = 0; r_ready = 0; r_num = 0;
    step(); step();
    chk("rst_valid", valid, 0); chk("rst_data", data, 0); chk("rst_strb", strb, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_cnt", cnt, 0);
    rst_n = 1;
    step();
    // counter burst of 4, ready high
    go(16'd4, 1'b0);
    chk("c4_busy", busy, 1); chk("c4_v0", valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("c4_valid", valid, 1); chk("c4_data", data, 64'(i)); chk("c4_cnt", cnt, 16'(i));
      if (i == 0) chk("c4_strb", strb, 8'hFF);
    end
    step();
    chk("c4_done", done, 1); chk("c4_vlow", valid, 0); chk("c4_fcnt", cnt, 4); chk("c4_idle", busy, 0);
    step();
    chk("c4_done1", done, 0); chk("c4_hold", cnt, 4);
    // backpressure: ready low for 3 cycles while valid
    ready = 0;
    go(16'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", valid, 1); chk("bp_data", data, 0); chk("bp_cnt", cnt, 0);
    end
    ready = 1;
    step();
    chk("bp_b1", data, 1); chk("bp_c1", cnt, 1); chk("bp_v1", valid, 1);
    step();
    chk("bp_done", done, 1); chk("bp_cnt2", cnt, 2); chk("bp_vlow", valid, 0);
    step();
    // zero-beat burst
    go(16'd0, 1'b0);
    chk("z_done", done, 1); chk("z_valid", valid, 0); chk("z_cnt", cnt, 0); chk("z_busy", busy, 0);
    step();
    chk("z_done1", done, 0); chk("z_valid1", valid, 0);
    // LFSR data, replicated across 64 bits
    go(16'd2, 1'b1);
    step();
    chk("l_d0", data, 64'hFFFFFFFF_FFFFFFFF);
    step();
    chk("l_d1", data, 64'hFFDFFFFC_FFDFFFFC);
    step();
    chk("l_done", done, 1);
    step();
    // clear after 3 of 10 beats
    go(16'd10, 1'b0);
    step(); step(); step(); step();
    chk("cl_pre", cnt, 3); chk("cl_pre_d", data, 3);
    clear = 1;
    step();
    clear = 0;
    chk("cl_valid", valid, 0); chk("cl_busy", busy, 0); chk("cl_cnt", cnt, 0); chk("cl_done", done, 0);
    chk("cl_data", data, 0);
    step();
    chk("cl_done1", done, 0);
    go(16'd2, 1'b0);
    step();
    chk("cl_re_v", valid, 1); chk("cl_re_d", data, 0);
    step(); step();
    chk("cl_re_done", done, 1);
    step();
    // clear wins over a simultaneous start
    clear = 1; num = 16'd5; start = 1;
    step();
    clear = 0; start = 0;
    chk("cs_busy", busy, 0);
    step();
    chk("cs_busy1", busy, 0); chk("cs_valid", valid, 0);
    // 64 beats against a randomized sink with THRESH=128
    @(negedge clk);
    r_num = 16'd64; r_start = 1;
    @(negedge clk);
    r_start = 0;
    expd = 0; drops = 0; dones = 0; bad_data = 0; tail = 0; prev_v = 0; prev_hs = 0;
    for (int c = 0; c < 5000 && tail < 8; c++) begin
      @(negedge clk);
      if (prev_v && !prev_hs && !r_valid) drops++;
      if (r_done) dones++;
      if (dones > 0) tail++;
      r_ready = 1'($urandom);
      h = r_valid & r_ready;
      if (h) begin
        if (r_data != 32'(expd)) bad_data++;
        expd++;
      end
      prev_v = r_valid; prev_hs = h;
    end
    chk("rnd_hs", expd, 64); chk("rnd_data", bad_data, 0); chk("rnd_drop", drops, 0);
    chk("rnd_dones", dones, 1); chk("rnd_cnt", r_cnt, 64); chk("rnd_vlow", r_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hwpe_stream_traffic_source.md
# hwpe_stream_traffic_source

Synthesizable HWPE-Stream source that emits a programmed number of beats with a deterministic, pseudo-random valid-stall pattern. It is the transmit-side counterpart to the bench's ready-randomizing sink, and sits at the upstream end of a stream under test. Because the LFSR-driven stalls are reproducible, benches can predict exact cycles and data.

## Interface
- DATA_WIDTH, 32: stream data width; must be a multiple of 32, ≥32.
- STALL_THRESH, 0: 0..255; a new beat is offered only when stall_lfsr[7:0] ≥ STALL_THRESH.
- STALL_SEED, 16'hACE1: stall LFSR reset seed; must be non-zero.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- clear_i  in  1  synchronous abort; same effect as reset.
- start_i  in  1  start a burst; sampled only in IDLE.
- num_beats_i  in  16  beats in the burst; sampled with start_i.
- pattern_i  in  1  0 = counter data, 1 = LFSR data; sampled with start_i.
- data_o  hwpe_stream_intf_stream.source  DATA_WIDTH  drives valid, data, strb; receives ready.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse at burst completion.
- beat_cnt_o  out  16  handshakes completed in the current/last burst.

## Operation
- FSM states IDLE, RUN, DONE. Reset/clear force IDLE.
- IDLE:
  - start_i=1 and num_beats_i≠0: latch count and pattern, zero beat_cnt_o, go RUN.
  - start_i=1 and num_beats_i=0: zero beat_cnt_o, go DONE.
- RUN:
  - Stall LFSR (16-bit Fibonacci, x^16+x^14+x^13+x^11+1) advances every RUN cycle.
  - When valid is low, or a handshake occurs this cycle, and beats remain after this cycle: next valid = (stall_lfsr[7:0] ≥ STALL_THRESH).
  - While valid=1 and ready=0, valid, data and strb hold stable; no new offer decision is taken.
  - Handshake = valid & ready. It increments beat_cnt_o and advances the data generator.
  - On the handshake with beat_cnt_o = count−1: valid drops next cycle, go DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. beat_cnt_o holds until the next start.
- Data generation:
  - Counter mode: data = beat index, zero-extended.
  - LFSR mode: data LFSR is a 32-bit Galois right-shift, taps 0x80200003, seed 0xFFFFFFFF, reseeded at each start. Its value is replicated across DATA_WIDTH.
  - strb is always all ones.
- start_i is ignored outside IDLE.
- clear_i mid-beat drops valid regardless of ready. This is an intentional test feature; no done pulse is produced.

## Timing
- Reset/clear values:
  - valid=0, data=0, strb=0, busy_o=0, done_o=0, beat_cnt_o=0.
  - State IDLE; stall LFSR = STALL_SEED; data LFSR = 0xFFFFFFFF.
- All outputs are registered; no combinational path from ready to any output.
- start_i high at edge k: busy_o=1 after edge k. The first valid is possible after edge k+1, i.e. one-cycle minimum latency.
- With STALL_THRESH=0 and ready held high: N beats appear back-to-back in the N cycles after edge k+1. done_o is high in the following cycle.
- Zero-beat burst: done_o is high in the cycle after the start edge; valid never rises.
- beat_cnt_o wraps only at 16 bits, which cannot occur because num_beats_i ≤ 65535.
- Reset or clear asserted in the same cycle as start_i wins.

## Test plan
- STALL_THRESH=0, counter mode, N=4, ready=1:
  - data 0,1,2,3 in four consecutive cycles.
  - done_o pulses once; beat_cnt_o=4; valid low afterwards.
- STALL_THRESH=0, N=2, ready=0 for 3 cycles while valid=1:
  - valid and data=0 stay stable for all 3 cycles with no increment.
  - On release: beat 0, then beat 1, then done.
- N=0 start:
  - No valid ever.
  - done_o high exactly one cycle after the start edge; beat_cnt_o=0.
- LFSR mode, STALL_THRESH=0, N=2, ready=1:
  - data words 0xFFFFFFFF then 0xFFDFFFFC, replicated per 32 bits.
- clear_i asserted during RUN after 3 of 10 beats:
  - Next cycle: valid=0, busy_o=0, beat_cnt_o=0, no done pulse.
  - A subsequent start reproduces the identical stall pattern.
- STALL_THRESH=128, N=64, ready randomized by the sink:
  - Exactly 64 handshakes with data 0..63 in order.
  - valid never falls without a handshake; done_o pulses once.
